// File: rtl/key_pkg.sv
// Shared definitions for the key debounce filter: FSM state encoding and default filter length.
package key_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    DOWN        = 2'd2,
    FILTER_UP   = 2'd3
  } key_fsm_t;

endpackage

// File: rtl/key_filter_if.sv
// Key filter signal bundle: raw active-low key in, debounced level and confirmation pulse out.
interface key_filter_if;

  logic key_in;
  logic key_flag;
  logic key_state;

  modport master (output key_in, input key_flag, input key_state);
  modport slave  (input key_in, output key_flag, output key_state);

endinterface

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for the raw key, plus a delayed copy used for edge detection.
module key_sync_edge
  import key_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_sync,
  output logic key_neg,
  output logic key_pos
);

  logic sync_1;
  logic sync_2;
  logic key_prev;

  // Flops reset to 1 so a key held low through reset is seen as a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1   <= 1'b1;
      sync_2   <= 1'b1;
      key_prev <= 1'b1;
    end else begin
      sync_1   <= key_in;
      sync_2   <= sync_1;
      key_prev <= sync_2;
    end
  end

  assign key_sync = sync_2;
  assign key_neg  = key_prev & ~sync_2;
  assign key_pos  = ~key_prev & sync_2;

endmodule

// File: rtl/key_filter.sv
// Debounce FSM: a level change is confirmed only after DEBOUNCE_CYCLES edge-free cycles.
module key_filter
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  key_filter_if.slave  kif
);

  localparam int unsigned        CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]      CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  key_fsm_t      state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          flag_r, flag_nx;
  logic          kstate_r, kstate_nx;
  logic          key_sync, key_neg, key_pos;

  key_sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .key_in   (kif.key_in),
    .key_sync (key_sync),
    .key_neg  (key_neg),
    .key_pos  (key_pos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      flag_r   <= 1'b0;
      kstate_r <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      flag_r   <= flag_nx;
      kstate_r <= kstate_nx;
    end
  end

  // Bounce edges are tested before the terminal count so a coinciding edge aborts.
  // The level qualifier on confirmation is implied by the edge check; it keeps the
  // synchronized level in the decision path.
  always_comb begin
    state_nx  = state;
    cnt_nx    = '0;
    flag_nx   = 1'b0;
    kstate_nx = kstate_r;
    case (state)
      IDLE: begin
        if (key_neg) state_nx = FILTER_DOWN;
      end
      FILTER_DOWN: begin
        if (key_pos) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST && !key_sync) begin
          state_nx  = DOWN;
          flag_nx   = 1'b1;
          kstate_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DOWN: begin
        if (key_pos) state_nx = FILTER_UP;
      end
      FILTER_UP: begin
        if (key_neg) begin
          state_nx = DOWN;
        end else if (cnt == CNT_LAST && key_sync) begin
          state_nx  = IDLE;
          flag_nx   = 1'b1;
          kstate_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign kif.key_flag  = flag_r;
  assign kif.key_state = kstate_r;

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with a run-length reference model checked every cycle.
module tb_key_filter;

  localparam int unsigned N = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic cmp_en = 1'b0;

  key_filter_if kif ();

  key_filter #(.DEBOUNCE_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #10 clk = ~clk;

  // Reference model: a level is confirmed once the raw key has been sampled opposite
  // to the confirmed level on N+1 consecutive edges; the outputs follow two edges later.
  logic        m_level, p1, p2, m_flag, m_state;
  int unsigned m_run;

  always @(posedge clk) begin
    if (rst) begin
      m_level <= 1'b1;
      m_run   <= 0;
      p1      <= 1'b0;
      p2      <= 1'b0;
      m_flag  <= 1'b0;
      m_state <= 1'b1;
    end else begin
      m_flag <= p2;
      if (p2) m_state <= ~m_state;
      p2 <= p1;
      if (kif.key_in == m_level) begin
        m_run <= 0;
        p1    <= 1'b0;
      end else if (m_run + 1 == N + 1) begin
        m_level <= kif.key_in;
        m_run   <= 0;
        p1      <= 1'b1;
      end else begin
        m_run <= m_run + 1;
        p1    <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_flag", kif.key_flag, m_flag);
      check("model_state", kif.key_state, m_state);
    end
  end

  // Drive a level for a number of cycles; count flag pulses and the cycle of the first one.
  task automatic hold(input logic lvl, input int unsigned cyc,
                      output int unsigned nflags, output int unsigned first_at);
    nflags   = 0;
    first_at = 0;
    kif.key_in = lvl;
    for (int unsigned i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (kif.key_flag) begin
        nflags++;
        if (first_at == 0) first_at = i + 1;
      end
    end
  endtask

  initial begin
    int unsigned nf, fa, tot;
    kif.key_in = 1'b1;
    rst = 1'b1;

    // Reset: 1 us with key released
    repeat (2) @(negedge clk);
    for (int unsigned i = 0; i < 48; i++) begin
      check("reset_flag", kif.key_flag, 0);
      check("reset_state", kif.key_state, 1);
      @(negedge clk);
    end
    rst = 1'b0;
    cmp_en = 1'b1;

    // Bounce: five toggles 1 us apart, the last one starts the press
    tot = 0;
    hold(1'b0, 50, nf, fa); tot += nf;
    hold(1'b1, 50, nf, fa); tot += nf;
    hold(1'b0, 50, nf, fa); tot += nf;
    hold(1'b1, 50, nf, fa); tot += nf;
    check("bounce_flags", tot, 0);
    check("bounce_state", kif.key_state, 1);

    // Press: low held 205 us
    hold(1'b0, 10250, nf, fa);
    check("press_flags", nf, 1);
    check("press_latency", fa, N + 3);
    check("press_state", kif.key_state, 0);

    // Release: high glitches around a 195 us low, then high held 205 us
    tot = 0;
    hold(1'b1, 50, nf, fa); tot += nf;
    hold(1'b0, 50, nf, fa); tot += nf;
    hold(1'b1, 50, nf, fa); tot += nf;
    hold(1'b0, 9750, nf, fa); tot += nf;
    check("glitch_flags", tot, 0);
    check("glitch_state", kif.key_state, 0);
    hold(1'b1, 10250, nf, fa);
    check("release_flags", nf, 1);
    check("release_latency", fa, N + 3);
    check("release_state", kif.key_state, 1);

    // Boundary: N-1 cycles low is rejected
    tot = 0;
    hold(1'b0, N - 1, nf, fa); tot += nf;
    hold(1'b1, 200, nf, fa); tot += nf;
    check("short_low_flags", tot, 0);
    check("short_low_state", kif.key_state, 1);

    // Boundary: a low just past the filter length is confirmed, then released
    hold(1'b0, N + 1, nf, fa);
    check("long_low_in_window", nf, 0);
    hold(1'b1, 5100, nf, fa);
    check("long_low_total_flags", nf, 2);
    check("long_low_press_at", fa, 2);
    check("long_low_state", kif.key_state, 1);

    // Reset 50 us into the press filter aborts it
    hold(1'b0, 2500, nf, fa);
    check("midfilter_pre_flags", nf, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 200, nf, fa);
    check("midfilter_flags", nf, 0);
    check("midfilter_state", kif.key_state, 1);

    // Key held low through reset release is confirmed after the normal filter time
    kif.key_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 5200, nf, fa);
    check("low_after_reset_flags", nf, 1);
    check("low_after_reset_latency", fa, N + 3);
    check("low_after_reset_state", kif.key_state, 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
